// File: rtl/sd_mode_ctrl.sv
// sd_mode_ctrl: measures line period and lines/frame, qualifies a stable mode and gates the scandoubled path; optional SD_CTRL_AUTOBYPASS_EN bypasses 31 kHz sources.
// Latency: inputs registered then edge-detected (2 cycles), locked trails the FSM by 1 cycle; no backpressure, paced by the video timing.
module sd_mode_ctrl #(
    parameter int CNT_W         = 11,
    parameter int TOL           = 2,
    parameter int LOCK_FRAMES   = 4,
    parameter int LOSS_FRAMES   = 2,
    parameter int MIN_LINES     = 240,
    parameter int MAX_LINES     = 330,
    parameter int BYPASS_PERIOD = 900
) (
    input  logic             clk_x2,
    input  logic             reset,
    input  logic             hs_in,
    input  logic             vs_in,
    input  logic [1:0]       scanlines_req,
    input  logic             sd_disable,
    output logic [CNT_W-1:0] hs_period,
    output logic [9:0]       lines,
    output logic             locked,
    output logic             sd_active,
    output logic [1:0]       scanlines
);
    typedef enum logic [1:0] {ST_SEARCH, ST_VERIFY, ST_LOCKED, ST_LOST} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TOL_C    = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] BYP_LIM  = CNT_W'(BYPASS_PERIOD);
    localparam logic [9:0]       LINE_MAX = 10'h3FF;
    localparam logic [9:0]       MIN_L    = 10'(MIN_LINES);
    localparam logic [9:0]       MAX_L    = 10'(MAX_LINES);
    localparam logic [3:0]       LOCK_N   = 4'(LOCK_FRAMES);
    localparam logic [3:0]       LOSS_N   = 4'(LOSS_FRAMES);
`ifdef SD_CTRL_AUTOBYPASS_EN
    localparam bit AUTOBYPASS = 1'b1;
`else
    localparam bit AUTOBYPASS = 1'b0;
`endif

    logic             hs_q, hs_d, hs_prev_q, hs_prev_d;
    logic             vs_q, vs_d, vs_prev_q, vs_prev_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d, prev_period_q, prev_period_d, hs_period_q, hs_period_d;
    logic [9:0]       lcnt_q, lcnt_d, prev_lines_q, prev_lines_d, lines_q, lines_d;
    logic             frame_bad_q, frame_bad_d;
    state_t           state_q, state_d;
    logic [3:0]       good_q, good_d, miss_q, miss_d;
    logic             locked_q, locked_d, sd_active_q, sd_active_d;
    logic [1:0]       scanlines_q, scanlines_d;

    logic             hs_fall, vs_fall, timeout, line_ok, bad_inc, frame_ok, bypass;
    logic [CNT_W-1:0] cur_period, period_diff, last_period;
    logic [9:0]       lcnt_inc;

    always_comb begin
        hs_d      = hs_in;
        hs_prev_d = hs_q;
        vs_d      = vs_in;
        vs_prev_d = vs_q;
    end

    assign hs_fall = hs_prev_q & ~hs_q;
    assign vs_fall = vs_prev_q & ~vs_q;
    assign timeout = (hcnt_q == CNT_MAX);

    // The capture cycle itself is counted, so a line of P cycles measures P.
    always_comb begin
        cur_period  = timeout ? CNT_MAX : hcnt_q + 1'b1;
        period_diff = (cur_period >= prev_period_q) ? cur_period - prev_period_q
                                                    : prev_period_q - cur_period;
        line_ok     = (period_diff <= TOL_C);
        lcnt_inc    = lcnt_q;
        bad_inc     = frame_bad_q;
        last_period = prev_period_q;
        if (hs_fall) begin
            lcnt_inc    = (lcnt_q == LINE_MAX) ? lcnt_q : lcnt_q + 1'b1;
            bad_inc     = frame_bad_q | ~line_ok;
            last_period = cur_period;
        end
        frame_ok = ~bad_inc && (lcnt_inc >= MIN_L) && (lcnt_inc <= MAX_L)
                   && (lcnt_inc == prev_lines_q);
    end

    always_comb begin
        hcnt_d        = hs_fall ? '0 : cur_period;
        prev_period_d = last_period;
        lcnt_d        = lcnt_inc;
        frame_bad_d   = bad_inc;
        prev_lines_d  = prev_lines_q;
        if (vs_fall) begin
            lcnt_d       = '0;
            frame_bad_d  = 1'b0;
            prev_lines_d = lcnt_inc;
        end
    end

    // Loss of hsync overrides any frame verdict arriving in the same cycle.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        miss_d  = miss_q;
        if (timeout) begin
            state_d = ST_SEARCH;
            good_d  = '0;
            miss_d  = '0;
        end else if (vs_fall) begin
            unique case (state_q)
                ST_SEARCH: if (frame_ok) begin
                    good_d  = 4'd1;
                    state_d = (LOCK_N == 4'd1) ? ST_LOCKED : ST_VERIFY;
                end
                ST_VERIFY: if (frame_ok) begin
                    good_d = good_q + 4'd1;
                    if (good_q + 4'd1 == LOCK_N) state_d = ST_LOCKED;
                end else begin
                    good_d  = '0;
                    state_d = ST_SEARCH;
                end
                ST_LOCKED: if (!frame_ok) begin
                    miss_d  = 4'd1;
                    state_d = (LOSS_N == 4'd1) ? ST_SEARCH : ST_LOST;
                end
                ST_LOST: if (frame_ok) begin
                    miss_d  = '0;
                    state_d = ST_LOCKED;
                end else if (miss_q + 4'd1 == LOSS_N) begin
                    miss_d  = '0;
                    state_d = ST_SEARCH;
                end else begin
                    miss_d = miss_q + 4'd1;
                end
                default: state_d = ST_SEARCH;
            endcase
        end
    end

    always_comb begin
        hs_period_d = hs_period_q;
        lines_d     = lines_q;
        if (state_d == ST_LOCKED && state_q != ST_LOCKED) begin
            hs_period_d = last_period;
            lines_d     = lcnt_inc;
        end
        locked_d = (state_q == ST_LOCKED) || (state_q == ST_LOST);
        bypass   = AUTOBYPASS && locked_q && (hs_period_q < BYP_LIM);
        sd_active_d = sd_active_q;
        if (!locked_q || sd_disable || bypass) sd_active_d = 1'b0;
        else if (vs_fall)                      sd_active_d = 1'b1;
        // Scanline level only moves on a frame boundary, except when the path shuts off.
        scanlines_d = scanlines_q;
        if (!sd_active_d)  scanlines_d = 2'b00;
        else if (vs_fall)  scanlines_d = scanlines_req;
    end

    always_ff @(posedge clk_x2 or posedge reset) begin
        if (reset) begin
            hs_q          <= 1'b0;
            hs_prev_q     <= 1'b0;
            vs_q          <= 1'b0;
            vs_prev_q     <= 1'b0;
            hcnt_q        <= '0;
            prev_period_q <= '0;
            hs_period_q   <= '0;
            lcnt_q        <= '0;
            prev_lines_q  <= '0;
            lines_q       <= '0;
            frame_bad_q   <= 1'b0;
            state_q       <= ST_SEARCH;
            good_q        <= '0;
            miss_q        <= '0;
            locked_q      <= 1'b0;
            sd_active_q   <= 1'b0;
            scanlines_q   <= '0;
        end else begin
            hs_q          <= hs_d;
            hs_prev_q     <= hs_prev_d;
            vs_q          <= vs_d;
            vs_prev_q     <= vs_prev_d;
            hcnt_q        <= hcnt_d;
            prev_period_q <= prev_period_d;
            hs_period_q   <= hs_period_d;
            lcnt_q        <= lcnt_d;
            prev_lines_q  <= prev_lines_d;
            lines_q       <= lines_d;
            frame_bad_q   <= frame_bad_d;
            state_q       <= state_d;
            good_q        <= good_d;
            miss_q        <= miss_d;
            locked_q      <= locked_d;
            sd_active_q   <= sd_active_d;
            scanlines_q   <= scanlines_d;
        end
    end

    assign hs_period = hs_period_q;
    assign lines     = lines_q;
    assign locked    = locked_q;
    assign sd_active = sd_active_q;
    assign scanlines = scanlines_q;
endmodule

// File: tb/tb_sd_mode_ctrl.sv
// Bench for sd_mode_ctrl with scaled-down timing (short lines, few lines per frame) against a frame-level model.
module tb_sd_mode_ctrl;
    localparam int CNT_W         = 8;
    localparam int TOL           = 2;
    localparam int LOCK_FRAMES   = 4;
    localparam int LOSS_FRAMES   = 2;
    localparam int MIN_LINES     = 10;
    localparam int MAX_LINES     = 14;
    localparam int BYPASS_PERIOD = 40;
    localparam int CMAX          = (1 << CNT_W) - 1;
    localparam int HS_W          = 8;

    logic             clk_x2 = 1'b0;
    logic             reset = 1'b1;
    logic             hs_in = 1'b1;
    logic             vs_in = 1'b1;
    logic [1:0]       scanlines_req = 2'b00;
    logic             sd_disable = 1'b0;
    logic [CNT_W-1:0] hs_period;
    logic [9:0]       lines;
    logic             locked;
    logic             sd_active;
    logic [1:0]       scanlines;

    sd_mode_ctrl #(
        .CNT_W(CNT_W), .TOL(TOL), .LOCK_FRAMES(LOCK_FRAMES), .LOSS_FRAMES(LOSS_FRAMES),
        .MIN_LINES(MIN_LINES), .MAX_LINES(MAX_LINES), .BYPASS_PERIOD(BYPASS_PERIOD)
    ) dut (
        .clk_x2(clk_x2), .reset(reset), .hs_in(hs_in), .vs_in(vs_in),
        .scanlines_req(scanlines_req), .sd_disable(sd_disable),
        .hs_period(hs_period), .lines(lines), .locked(locked),
        .sd_active(sd_active), .scanlines(scanlines)
    );

    always #5 clk_x2 = ~clk_x2;

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: lines are kept as a queue of measured periods; a frame is judged as a whole when it ends.
    bit hs_s1, hs_s2, vs_s1, vs_s2;
    int m_since, m_last, m_ref, m_prev_lines;
    int per_q[$];
    bit m_lk;
    int m_run, m_bad, m_hs_period, m_lines, m_scan;
    bit m_locked, m_sda;

    task automatic model_reset();
        hs_s1 = 0; hs_s2 = 0; vs_s1 = 0; vs_s2 = 0;
        m_since = 0; m_last = 0; m_ref = 0; m_prev_lines = 0;
        per_q.delete();
        m_lk = 0; m_run = 0; m_bad = 0; m_hs_period = 0; m_lines = 0;
        m_scan = 0; m_locked = 0; m_sda = 0;
    endtask

    function automatic bit frame_good();
        int n = (per_q.size() > 1023) ? 1023 : per_q.size();
        int r = m_ref;
        if (n < MIN_LINES || n > MAX_LINES || n != m_prev_lines) return 1'b0;
        foreach (per_q[i]) begin
            int d = per_q[i] - r;
            if (d < 0) d = -d;
            if (d > TOL) return 1'b0;
            r = per_q[i];
        end
        return 1'b1;
    endfunction

    always @(posedge clk_x2) begin : model
        bit hf, vf, to, ok, byp;
        if (reset) begin
            model_reset();
        end else begin
            hf = hs_s2 && !hs_s1;
            vf = vs_s2 && !vs_s1;
            to = (m_since == CMAX);
            ok = 1'b0;
            byp = 1'b0;
`ifdef SD_CTRL_AUTOBYPASS_EN
            byp = m_locked && (m_hs_period < BYPASS_PERIOD);
`endif
            if (!m_locked || sd_disable || byp) m_sda = 1'b0;
            else if (vf)                        m_sda = 1'b1;
            if (!m_sda)   m_scan = 0;
            else if (vf)  m_scan = int'(scanlines_req);
            m_locked = m_lk;
            if (hf) begin
                per_q.push_back((m_since == CMAX) ? CMAX : m_since + 1);
                m_last  = per_q[per_q.size() - 1];
                m_since = 0;
            end else if (m_since < CMAX) begin
                m_since++;
            end
            if (vf) begin
                ok = frame_good();
                m_prev_lines = (per_q.size() > 1023) ? 1023 : per_q.size();
                m_ref = m_last;
                per_q.delete();
            end
            if (to) begin
                m_lk = 0; m_run = 0; m_bad = 0;
            end else if (vf) begin
                if (!m_lk) begin
                    if (ok) begin
                        m_run++;
                        if (m_run == LOCK_FRAMES) begin
                            m_lk = 1; m_bad = 0;
                            m_hs_period = m_last; m_lines = m_prev_lines;
                        end
                    end else begin
                        m_run = 0;
                    end
                end else if (ok) begin
                    if (m_bad > 0) begin
                        m_hs_period = m_last; m_lines = m_prev_lines;
                    end
                    m_bad = 0;
                end else begin
                    m_bad++;
                    if (m_bad == LOSS_FRAMES) begin
                        m_lk = 0; m_run = 0; m_bad = 0;
                    end
                end
            end
            hs_s2 = hs_s1; hs_s1 = hs_in;
            vs_s2 = vs_s1; vs_s1 = vs_in;
        end
    end

    always @(posedge clk_x2) begin
        #2;
        if (cmp_en) begin
            check("locked",    int'(locked),    int'(m_locked));
            check("sd_active", int'(sd_active), int'(m_sda));
            check("scanlines", int'(scanlines), m_scan);
            check("hs_period", int'(hs_period), m_hs_period);
            check("lines",     int'(lines),     m_lines);
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk_x2);
    endtask

    task automatic line(int period, bit vstart);
        hs_in = 1'b0;
        if (vstart) vs_in = 1'b0;
        tick(HS_W);
        hs_in = 1'b1;
        vs_in = 1'b1;
        tick(period - HS_W);
    endtask

    task automatic frame(int n, int period, int bad_idx, bit jitter, int req_mid);
        for (int i = 0; i < n; i++) begin
            int p;
            p = period;
            if (jitter) p += int'($urandom_range(0, 1));
            if (i == bad_idx) p += TOL + 2;
            if (i == n / 2 && req_mid >= 0) scanlines_req = req_mid[1:0];
            line(p, i == 0);
        end
    endtask

    initial begin
        tick(3);
        cmp_en = 1'b1;
        check("rst_locked",    int'(locked), 0);
        check("rst_sd_active", int'(sd_active), 0);
        check("rst_scanlines", int'(scanlines), 0);
        check("rst_hs_period", int'(hs_period), 0);
        check("rst_lines",     int'(lines), 0);
        reset = 1'b0;

        // Stable 12-line, 56-cycle mode: lock on the 6th vs fall, doubler on at the 7th.
        repeat (5) frame(12, 56, -1, 1'b0, -1);
        check("prelock_locked", int'(locked), 0);
        frame(12, 56, -1, 1'b0, -1);
        check("lock_locked", int'(locked), 1);
        check("lock_sd_wait", int'(sd_active), 0);
        frame(12, 56, -1, 1'b0, -1);
        check("sd_on", int'(sd_active), 1);
        check("lock_period", int'(hs_period), 56);
        check("lock_lines", int'(lines), 12);
        check("model_period", m_hs_period, 56);

        // One bad frame -> LOST (still locked), good frame recovers, two bad frames unlock.
        frame(12, 56, 5, 1'b0, -1);
        frame(12, 56, -1, 1'b0, -1);
        check("lost_locked", int'(locked), 1);
        check("lost_sd", int'(sd_active), 1);
        frame(12, 56, 4, 1'b0, -1);
        frame(12, 56, 6, 1'b0, -1);
        check("miss1_locked", int'(locked), 1);
        frame(12, 56, -1, 1'b0, -1);
        check("unlock_locked", int'(locked), 0);
        check("unlock_sd", int'(sd_active), 0);

        repeat (5) frame(12, 56, -1, 1'b0, -1);
        check("relock_locked", int'(locked), 1);
        check("relock_sd", int'(sd_active), 1);

        // Scanline request changed mid-frame only takes effect at the next vs fall.
        frame(12, 56, -1, 1'b0, 2);
        check("scan_hold", int'(scanlines), 0);
        frame(12, 56, -1, 1'b0, -1);
        check("scan_apply", int'(scanlines), 2);

        // hsync lost: counter saturates, back to search without waiting for vsync.
        tick(CMAX + 20);
        check("to_locked", int'(locked), 0);
        check("to_sd", int'(sd_active), 0);
        check("to_scan", int'(scanlines), 0);
        check("to_period", int'(hs_period), 56);
        scanlines_req = 2'b00;

        repeat (8) frame(9, 56, -1, 1'b0, -1);
        check("short_locked", int'(locked), 0);
        repeat (4) begin
            frame(11, 56, -1, 1'b0, -1);
            frame(12, 56, -1, 1'b0, -1);
        end
        check("alt_locked", int'(locked), 0);

        // Fast (already 31 kHz) source.
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        scanlines_req = 2'b10;
        repeat (7) frame(12, 28, -1, 1'b0, -1);
        check("fast_locked", int'(locked), 1);
        check("fast_period", int'(hs_period), 28);
`ifdef SD_CTRL_AUTOBYPASS_EN
        check("fast_sd", int'(sd_active), 0);
        check("fast_scan", int'(scanlines), 0);
`else
        check("fast_sd", int'(sd_active), 1);
        check("fast_scan", int'(scanlines), 2);
`endif

        // Mid-frame reset, then random jitter, bad lines, line counts, requests and disables.
        frame(5, 56, -1, 1'b0, -1);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        for (int f = 0; f < 15; f++) begin
            int n, bad, req;
            n   = ($urandom_range(0, 5) == 0) ? 11 : 12;
            bad = ($urandom_range(0, 4) == 0) ? int'($urandom_range(2, 8)) : -1;
            req = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
            sd_disable = ($urandom_range(0, 5) == 0);
            frame(n, 56, bad, 1'b1, req);
        end
        tick(2);
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
